// File: rtl/nim_display_pkg.sv
// Shared types and seven-segment encoding for the Nim scoreboard display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package nim_display_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Non-BCD codes render as a lone middle bar so bad counter values are visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder with a blank override.
module bcd_to_seg7
    import nim_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : bcd_to_seg(bcd);

endmodule

// File: rtl/scoreboard_display.sv
// Four-digit multiplexed common-anode driver: frame snapshots, guard interval,
// leading-zero blanking on the tens digits and a blink mode.
module scoreboard_display
    import nim_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int BLINK_DIV   = 25000000,
    parameter int LZ_BLANK    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] leftscoreLeft,
    input  logic [3:0] leftscoreRight,
    input  logic [3:0] rightscoreLeft,
    input  logic [3:0] rightscoreRight,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_DIV - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    digit_idx_t         idx_q, idx_d;
    logic [3:0][3:0]    snap_q, snap_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic               phase_q, phase_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               wrap;
    logic               lit;
    logic [3:0]         cur_bcd;
    logic               cur_blank;
    logic [6:0]         dec_seg;

    assign cur_bcd   = snap_q[idx_q];
    assign cur_blank = (LZ_BLANK != 0) && idx_q[0] && (cur_bcd == 4'd0);

    bcd_to_seg7 u_dec (
        .bcd   (cur_bcd),
        .blank (cur_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        snap_d  = snap_q;
        if (wrap && idx_q == 2'd3)
            snap_d = {leftscoreLeft, leftscoreRight, rightscoreLeft, rightscoreRight};

        bcnt_d  = '0;
        phase_d = 1'b0;
        if (blink) begin
            if (bcnt_q == BLK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BW'(1);
                phase_d = phase_q;
            end
        end

        // Dark phase uses the next phase value so the blackout lines up with the wrap.
        lit  = (cnt_q >= CNT_GUARD) && !phase_d;
        an_d  = lit ? ~(4'b0001 << idx_q) : 4'b1111;
        seg_d = lit ? dec_seg : SEG_BLANK;
        dp_d  = !(lit && idx_q == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
